// File: rtl/coin_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// coin_pkg: shared types and coin values for the coin input path.
// Revision: 1.0
// ----------------------------------------------------------------------------
package coin_pkg;

  typedef enum logic [2:0] {
    ARM          = 3'd0,
    IDLE         = 3'd1,
    PRESS_WAIT   = 3'd2,
    PRESSED      = 3'd3,
    RELEASE_WAIT = 3'd4
  } debounce_state_t;

  localparam int COIN_100_UNITS     = 1;
  localparam int COIN_500_UNITS     = 5;
  localparam int CREDIT_MAX_DEFAULT = 9;

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// button_debouncer: synchronise, normalise and debounce one raw coin button.
// Revision: 1.0
// ----------------------------------------------------------------------------
module button_debouncer
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press_event
);

  localparam int             CNT_W          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic           RELEASED_LEVEL = (BTN_ACTIVE_LOW != 0);

  logic [1:0]       sync_q, sync_d;
  logic             pressed;
  debounce_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    pressed = sync_q[1] ^ RELEASED_LEVEL;
  end

  // ARM behaves like a held button: a stable release is needed before any press counts.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_event = 1'b0;
    unique case (state_q)
      ARM: begin
        if (pressed) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = PRESSED;
          press_event = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ARM;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q  <= {2{RELEASED_LEVEL}};
      state_q <= ARM;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/coin_input_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// coin_input_conditioner: debounced coin buttons feeding a saturating credit.
// Revision: 1.0
// ----------------------------------------------------------------------------
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CREDIT_MAX      = CREDIT_MAX_DEFAULT,
  parameter int CREDIT_W        = 4,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_100_btn,
  input  logic                coin_500_btn,
  input  logic                credit_clear,
  input  logic                credit_lock,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_pulse_100,
  output logic                coin_pulse_500,
  output logic                coin_rejected,
  output logic                credit_full
);

  localparam logic [CREDIT_W:0]   MAX_EXT  = (CREDIT_W + 1)'(CREDIT_MAX);
  localparam logic [CREDIT_W:0]   ADD_100  = (CREDIT_W + 1)'(COIN_100_UNITS);
  localparam logic [CREDIT_W:0]   ADD_500  = (CREDIT_W + 1)'(COIN_500_UNITS);
  localparam logic [CREDIT_W-1:0] MAX_CRED = CREDIT_W'(CREDIT_MAX);

  logic                ev_100, ev_500, any_ev;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                pulse_100_q, pulse_100_d;
  logic                pulse_500_q, pulse_500_d;
  logic                rejected_q, rejected_d;
  logic                full_q, full_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_btn_100 (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (coin_100_btn),
    .press_event (ev_100)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_btn_500 (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (coin_500_btn),
    .press_event (ev_500)
  );

  // One extra bit on the sum keeps the overflow compare from wrapping;
  // simultaneous coins are accepted or refused as a single amount.
  always_comb begin
    any_ev      = ev_100 | ev_500;
    sum         = {1'b0, credit_q} + (ev_100 ? ADD_100 : '0) + (ev_500 ? ADD_500 : '0);
    credit_d    = credit_q;
    pulse_100_d = 1'b0;
    pulse_500_d = 1'b0;
    rejected_d  = 1'b0;
    if (credit_clear) begin
      credit_d   = '0;
      rejected_d = any_ev;
    end else if (credit_lock) begin
      rejected_d = any_ev;
    end else if (any_ev) begin
      if (sum <= MAX_EXT) begin
        credit_d    = sum[CREDIT_W-1:0];
        pulse_100_d = ev_100;
        pulse_500_d = ev_500;
      end else begin
        rejected_d = 1'b1;
      end
    end
    full_d = (credit_d == MAX_CRED);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      credit_q    <= '0;
      pulse_100_q <= 1'b0;
      pulse_500_q <= 1'b0;
      rejected_q  <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      pulse_100_q <= pulse_100_d;
      pulse_500_q <= pulse_500_d;
      rejected_q  <= rejected_d;
      full_q      <= full_d;
    end
  end

  assign credit         = credit_q;
  assign coin_pulse_100 = pulse_100_q;
  assign coin_pulse_500 = pulse_500_q;
  assign coin_rejected  = rejected_q;
  assign credit_full    = full_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_input_conditioner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_coin_input_conditioner: directed stimulus against a run-length model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_coin_input_conditioner;

  localparam int D    = 4;
  localparam int CMAX = 9;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       coin_100_btn = 1'b1;
  logic       coin_500_btn = 1'b1;
  logic       credit_clear = 1'b0;
  logic       credit_lock  = 1'b0;
  logic [3:0] credit;
  logic       coin_pulse_100, coin_pulse_500, coin_rejected, credit_full;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CREDIT_MAX      (CMAX),
    .CREDIT_W        (4),
    .BTN_ACTIVE_LOW  (1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .coin_100_btn   (coin_100_btn),
    .coin_500_btn   (coin_500_btn),
    .credit_clear   (credit_clear),
    .credit_lock    (credit_lock),
    .credit         (credit),
    .coin_pulse_100 (coin_pulse_100),
    .coin_pulse_500 (coin_pulse_500),
    .coin_rejected  (coin_rejected),
    .credit_full    (credit_full)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: a debounced level flips once the synchronised input has disagreed
  // with it for a whole run; after reset the level counts as held.
  bit m_s1[2], m_s2[2], m_held[2], m_arming[2];
  int m_run[2];
  int m_credit;
  bit m_p100, m_p500, m_rej, m_full, m_valid;

  always @(posedge clock) begin
    bit pin_p[2];
    bit ev[2];
    int need, add;
    pin_p[0] = (coin_100_btn == 1'b0);
    pin_p[1] = (coin_500_btn == 1'b0);
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_held[b] = 1; m_arming[b] = 1; m_run[b] = 0;
      end
      m_credit = 0; m_p100 = 0; m_p500 = 0; m_rej = 0; m_full = 0; m_valid = 1;
    end else begin
      for (int b = 0; b < 2; b++) begin
        ev[b] = 0;
        if (m_s2[b] == m_held[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          need = (m_held[b] && m_arming[b]) ? D : D + 1;
          if (m_run[b] == need) begin
            m_held[b] = !m_held[b]; m_arming[b] = 0; m_run[b] = 0; ev[b] = m_held[b];
          end
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = pin_p[b];
      end
      add = (ev[0] ? 1 : 0) + (ev[1] ? 5 : 0);
      m_p100 = 0; m_p500 = 0; m_rej = 0;
      if (credit_clear) begin
        m_credit = 0; m_rej = (add != 0);
      end else if (credit_lock) begin
        m_rej = (add != 0);
      end else if (add != 0) begin
        if (m_credit + add <= CMAX) begin
          m_credit += add; m_p100 = ev[0]; m_p500 = ev[1];
        end else m_rej = 1;
      end
      m_full = (m_credit == CMAX);
    end
  end

  int cnt100 = 0, cnt500 = 0, cntrej = 0, cntboth = 0;

  always @(negedge clock) begin
    if (m_valid) begin
      check("credit", 32'(credit), 32'(m_credit));
      check("flags", {28'd0, coin_pulse_100, coin_pulse_500, coin_rejected, credit_full},
                     {28'd0, m_p100, m_p500, m_rej, m_full});
      if (coin_pulse_100) cnt100++;
      if (coin_pulse_500) cnt500++;
      if (coin_rejected) cntrej++;
      if (coin_pulse_100 && coin_pulse_500) cntboth++;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_counts();
    cnt100 = 0; cnt500 = 0; cntrej = 0; cntboth = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (6) tick();
  endtask

  task automatic press(input bit b100, input bit b500);
    if (b100) coin_100_btn = 1'b0;
    if (b500) coin_500_btn = 1'b0;
    repeat (10) tick();
    coin_100_btn = 1'b1;
    coin_500_btn = 1'b1;
    repeat (12) tick();
  endtask

  initial begin
    int first;
    repeat (2) tick();
    check("reset_credit", 32'(credit), 0);
    check("reset_flags", {28'd0, coin_pulse_100, coin_pulse_500, coin_rejected, credit_full}, 0);
    reset = 1'b1;
    repeat (5) tick();

    // Glitchy press, then a stable press held 20 cycles.
    clear_counts();
    coin_100_btn = 1'b0; tick();
    coin_100_btn = 1'b1; tick();
    coin_100_btn = 1'b0; tick();
    coin_100_btn = 1'b1; tick();
    coin_100_btn = 1'b0;
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (coin_pulse_100 && first < 0) first = k;
    end
    coin_100_btn = 1'b1;
    repeat (12) tick();
    check("glitch_latency", 32'(first), 7);
    check("glitch_one_pulse", 32'(cnt100), 1);
    check("glitch_credit", 32'(credit), 1);

    // Button held through reset release.
    clear_counts();
    coin_100_btn = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (30) tick();
    coin_100_btn = 1'b1;
    repeat (12) tick();
    check("held_no_pulse", 32'(cnt100 + cnt500 + cntrej), 0);
    check("held_credit", 32'(credit), 0);

    // 500, 100, then an overflowing 500.
    clear_counts();
    press(0, 1); check("c5", 32'(credit), 5);
    press(1, 0); check("c6", 32'(credit), 6);
    press(0, 1); check("c6_rej_credit", 32'(credit), 6);
    check("c6_rej_count", 32'(cntrej), 1);
    press(1, 0); check("c7", 32'(credit), 7);
    press(1, 0); check("c8", 32'(credit), 8);
    press(1, 0); check("c9", 32'(credit), 9);
    check("c9_full", 32'(credit_full), 1);
    check("model_c9", 32'(m_credit), 9);
    press(1, 0); check("c9_rej_credit", 32'(credit), 9);
    check("c9_rej_count", 32'(cntrej), 2);

    // Simultaneous coins accepted at credit 3.
    do_reset();
    press(1, 0); press(1, 0); press(1, 0);
    check("c3", 32'(credit), 3);
    clear_counts();
    press(1, 1);
    check("both_credit", 32'(credit), 9);
    check("both_together", 32'(cntboth), 1);
    check("both_full", 32'(credit_full), 1);

    // Simultaneous coins refused at credit 4.
    do_reset();
    press(1, 0); press(1, 0); press(1, 0); press(1, 0);
    check("c4", 32'(credit), 4);
    clear_counts();
    press(1, 1);
    check("both_rej_credit", 32'(credit), 4);
    check("both_rej_count", 32'(cntrej), 1);
    check("both_rej_nopulse", 32'(cnt100 + cnt500), 0);

    // Clear coinciding with a 100 press event.
    do_reset();
    press(0, 1); press(1, 0);
    check("c6b", 32'(credit), 6);
    coin_100_btn = 1'b0;
    repeat (6) tick();
    credit_clear = 1'b1;
    tick();
    credit_clear = 1'b0;
    check("clear_credit", 32'(credit), 0);
    check("clear_rejected", 32'(coin_rejected), 1);
    repeat (4) tick();
    coin_100_btn = 1'b1;
    repeat (12) tick();

    // Lock refuses a coin; after unlock a coin is accepted.
    clear_counts();
    credit_lock = 1'b1;
    press(0, 1);
    check("lock_credit", 32'(credit), 0);
    check("lock_rej", 32'(cntrej), 1);
    credit_lock = 1'b0;
    tick();
    press(0, 1);
    check("unlock_credit", 32'(credit), 5);
    check("unlock_pulse", 32'(cnt500), 1);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
